ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

Iterative RV32M multiply/divide unit at the execute end of the ID/EX pipeline register. Consumes the decoded operands and operation held in EX and computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over 32 iterations. Asserts a stall that freezes PC, IF/ID and ID/EX while the operation is in flight. Releases the result with its destination register tag for the EX/MEM register.

## Interface
- DATA_WIDTH, 32, operand and result width; only 32 is supported.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous and active-high.
- E_MulDiv  input  1  instruction in EX is an M-extension op; acts as the start request.
- E_Funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- E_SrcA  input  DATA_WIDTH  rs1 operand, after forwarding.
- E_SrcB  input  DATA_WIDTH  rs2 operand, after forwarding.
- E_Rd  input  5  destination register of the EX instruction.
- E_Flush  input  1  abort the current op; used on redirect or exception.
- MD_Stall  output  1  freeze PC, IF/ID and ID/EX.
- MD_Done  output  1  one-cycle pulse; result valid.
- MD_Result  output  DATA_WIDTH  result; holds its value until the next start.
- MD_Rd  output  5  destination tag captured at start.

## Operation
- States: IDLE, CALC, DONE.
- IDLE -> CALC when E_MulDiv=1. In the same edge:
  - latch the op, Rd and operand magnitudes.
  - latch the result-sign flag, computed as follows.
  - Signed operands for MULH and DIV/REM are both signed; for MULHSU only rs1 is signed.
  - MUL product sign = signA XOR signB.
  - Quotient sign = signA XOR signB.
  - Remainder sign = signA.
  - Clear the 6-bit iteration counter and the 64-bit accumulator.
- CALC, multiply: shift-add on unsigned magnitudes, one multiplier bit per cycle, LSB first, 64-bit accumulator.
- CALC, divide: restoring division, one quotient bit per cycle, MSB first, 33-bit partial remainder.
- CALC -> DONE when the counter reaches 31. On that edge, apply the sign correction (two's-complement negate) and select the result:
  - MUL: low 32 bits.
  - MULH/MULHSU/MULHU: high 32 bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- DONE -> IDLE unconditionally. E_MulDiv is ignored in DONE because the same instruction is still in EX.
- Divide by zero (SrcB=0):
  - quotient = 0xFFFFFFFF for both DIV and DIVU.
  - remainder = SrcA.
  - No trap.
- Signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF):
  - quotient = 0x80000000.
  - remainder = 0.
- E_Flush=1 in any state: next state IDLE, no MD_Done, MD_Result unchanged. Flush has priority over start.
- rst=1: state IDLE, counter 0, accumulator 0.

## Timing
- Reset values: MD_Stall=0, MD_Done=0, MD_Result=0, MD_Rd=0.
- MD_Stall = (IDLE & E_MulDiv & ~E_Flush) | CALC. It is combinational so that the start cycle already freezes the pipeline.
- Start accepted at edge T (IDLE, E_MulDiv=1). CALC occupies cycles T+1..T+32. DONE is the cycle after T+32: MD_Done=1 and MD_Stall=0, so ID/EX advances on that edge.
- Latency: 34 cycles from the start cycle to the MD_Done cycle. Back-to-back ops restart no earlier than the cycle after DONE.
- MD_Result and MD_Rd are registered and valid during the MD_Done cycle. They are held afterward.
- rst asserted mid-CALC: state returns to IDLE on that edge, and MD_Stall drops in the following cycle.

## Configuration
- MULDIV_EARLY_OUT_EN defined: divide by zero and signed overflow are detected in IDLE.
  - FSM goes directly to DONE with the special-case result.
  - MD_Done arrives in the cycle after the start; latency is 2 cycles.
  - MD_Stall is asserted only in the start cycle.
- Not defined: special cases run the full 32 iterations. The restoring algorithm plus sign correction yields the same values at the normal 34-cycle latency.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), Rd=5 -> MD_Result=0xFFFFFFEB, MD_Rd=5, MD_Done on the 34th cycle, MD_Stall high for exactly 33 cycles.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHU same operands -> 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 0x1234/0 -> 0xFFFFFFFF. REMU 0x1234/0 -> 0x1234. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same -> 0. Latency is 34 cycles without the macro and 2 cycles with MULDIV_EARLY_OUT_EN.
- E_Flush at cycle 10 of CALC -> IDLE next cycle, no MD_Done, MD_Result keeps its previous value, MD_Stall low.
- rst pulse mid-CALC, then a new DIVU 9/3 -> all outputs read 0 after reset. The new op yields 3 with full latency.

Source files
------------

// File: rtl/ex_muldiv_unit_if.sv
// ----------------------------------------------------------------------------
// ex_muldiv_unit_if
// Request/response bundle between the EX stage and the iterative RV32M
// multiply/divide unit.
//   master (EX stage): drives E_MulDiv, E_Funct3, E_SrcA, E_SrcB, E_Rd, E_Flush
//   slave  (unit)    : drives MD_Stall, MD_Done, MD_Result, MD_Rd
// Only DATA_WIDTH = 32 is supported.
// ----------------------------------------------------------------------------
interface ex_muldiv_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  E_MulDiv;
  logic [2:0]            E_Funct3;
  logic [DATA_WIDTH-1:0] E_SrcA;
  logic [DATA_WIDTH-1:0] E_SrcB;
  logic [4:0]            E_Rd;
  logic                  E_Flush;
  logic                  MD_Stall;
  logic                  MD_Done;
  logic [DATA_WIDTH-1:0] MD_Result;
  logic [4:0]            MD_Rd;

  modport master (
    output E_MulDiv, E_Funct3, E_SrcA, E_SrcB, E_Rd, E_Flush,
    input  MD_Stall, MD_Done, MD_Result, MD_Rd
  );

  modport slave (
    input  E_MulDiv, E_Funct3, E_SrcA, E_SrcB, E_Rd, E_Flush,
    output MD_Stall, MD_Done, MD_Result, MD_Rd
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ----------------------------------------------------------------------------
// ex_muldiv_unit
// Iterative RV32M multiply/divide unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/
// REMU), 32 iterations on operand magnitudes followed by sign correction.
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset
//   md_bus  - ex_muldiv_unit_if.slave: EX-stage operands/op/flush in,
//             stall, done pulse, result and destination tag out
// Configuration macro:
//   MULDIV_EARLY_OUT_EN - when defined, divide-by-zero and signed overflow
//                         finish straight from IDLE (2-cycle latency).
// ----------------------------------------------------------------------------
module ex_muldiv_unit (
  input  logic               clk,
  input  logic               rst,
  ex_muldiv_unit_if.slave    md_bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  // Multiply: left-shifting multiplicand. Divide: dividend in [31:0], MSB out.
  logic [63:0] mcand_q, mcand_d;
  // Multiply: right-shifting multiplier. Divide: divisor magnitude.
  logic [31:0] mplier_q, mplier_d;
  // Multiply: product. Divide: quotient shifted in at [0].
  logic [63:0] acc_q, acc_d;
  logic [31:0] rem_q, rem_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic [31:0] result_q, result_d;

  logic        sgn_a_s, sgn_b_s, a_neg_s, b_neg_s, start_neg_s;
  logic [31:0] mag_a_s, mag_b_s;
  logic [63:0] mul_acc_s, fin_prod_s;
  logic [32:0] rem_sh_s;
  logic        div_ge_s;
  logic [31:0] rem_sub_s, div_rem_s, fin_quo_s, fin_rem_s, fin_res_s;
  logic        special_s;
  logic [31:0] special_res_s;

  // Operand signedness, magnitudes and result-sign flag for the start edge
  always_comb begin
    sgn_a_s = 1'b0;
    sgn_b_s = 1'b0;
    case (md_bus.E_Funct3)
      3'b001, 3'b100, 3'b110: begin sgn_a_s = 1'b1; sgn_b_s = 1'b1; end
      3'b010:                 begin sgn_a_s = 1'b1; sgn_b_s = 1'b0; end
      default:                begin sgn_a_s = 1'b0; sgn_b_s = 1'b0; end
    endcase
    a_neg_s = sgn_a_s & md_bus.E_SrcA[31];
    b_neg_s = sgn_b_s & md_bus.E_SrcB[31];
    mag_a_s = a_neg_s ? (32'd0 - md_bus.E_SrcA) : md_bus.E_SrcA;
    mag_b_s = b_neg_s ? (32'd0 - md_bus.E_SrcB) : md_bus.E_SrcB;
    start_neg_s = 1'b0;
    case (md_bus.E_Funct3)
      // A zero divisor must give all-ones quotient, so never negate it.
      3'b100, 3'b101: start_neg_s = (a_neg_s ^ b_neg_s) & (md_bus.E_SrcB != 32'd0);
      3'b110, 3'b111: start_neg_s = a_neg_s;
      default:        start_neg_s = a_neg_s ^ b_neg_s;
    endcase
  end

  // Divide-by-zero / signed-overflow shortcut results
  always_comb begin
    special_s     = 1'b0;
    special_res_s = 32'd0;
`ifdef MULDIV_EARLY_OUT_EN
    if (md_bus.E_Funct3[2]) begin
      special_s = (md_bus.E_SrcB == 32'd0) |
                  (~md_bus.E_Funct3[0] & (md_bus.E_SrcA == 32'h8000_0000) &
                   (md_bus.E_SrcB == 32'hFFFF_FFFF));
    end else begin
      special_s = 1'b0;
    end
    case (md_bus.E_Funct3)
      3'b100:  special_res_s = (md_bus.E_SrcB == 32'd0) ? 32'hFFFF_FFFF : 32'h8000_0000;
      3'b101:  special_res_s = 32'hFFFF_FFFF;
      3'b110:  special_res_s = (md_bus.E_SrcB == 32'd0) ? md_bus.E_SrcA : 32'd0;
      3'b111:  special_res_s = md_bus.E_SrcA;
      default: special_res_s = 32'd0;
    endcase
`else
    special_s     = 1'b0;
    special_res_s = 32'd0;
`endif
  end

  // One iteration step plus sign-corrected result of the current values
  always_comb begin
    mul_acc_s = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
    rem_sh_s  = {rem_q, mcand_q[31]};
    div_ge_s  = (rem_sh_s >= {1'b0, mplier_q});
    rem_sub_s = rem_sh_s[31:0] - mplier_q;
    div_rem_s = div_ge_s ? rem_sub_s : rem_sh_s[31:0];
    fin_prod_s = neg_q ? (64'd0 - acc_d) : acc_d;
    fin_quo_s  = neg_q ? (32'd0 - acc_d[31:0]) : acc_d[31:0];
    fin_rem_s  = neg_q ? (32'd0 - rem_d) : rem_d;
    case (op_q)
      3'b000:                 fin_res_s = fin_prod_s[31:0];
      3'b001, 3'b010, 3'b011: fin_res_s = fin_prod_s[63:32];
      3'b100, 3'b101:         fin_res_s = fin_quo_s;
      3'b110, 3'b111:         fin_res_s = fin_rem_s;
      default:                fin_res_s = 32'd0;
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;
    if (md_bus.E_Flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (md_bus.E_MulDiv) begin
            op_d     = md_bus.E_Funct3;
            rd_d     = md_bus.E_Rd;
            mcand_d  = {32'd0, mag_a_s};
            mplier_d = mag_b_s;
            neg_d    = start_neg_s;
            acc_d    = 64'd0;
            rem_d    = 32'd0;
            cnt_d    = 6'd0;
            if (special_s) begin
              state_d  = S_DONE;
              result_d = special_res_s;
            end else begin
              state_d = S_CALC;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CALC: begin
          if (op_q[2]) begin
            acc_d   = {acc_q[62:0], div_ge_s};
            rem_d   = div_rem_s;
            mcand_d = {mcand_q[62:0], 1'b0};
          end else begin
            acc_d    = mul_acc_s;
            mcand_d  = {mcand_q[62:0], 1'b0};
            mplier_d = {1'b0, mplier_q[31:1]};
          end
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d  = S_DONE;
            result_d = fin_res_s;
          end else begin
            state_d = S_CALC;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= 3'd0;
      rd_q     <= 5'd0;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      acc_q    <= 64'd0;
      rem_q    <= 32'd0;
      cnt_q    <= 6'd0;
      neg_q    <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  // Stall is combinational so the start cycle already freezes the pipeline
  assign md_bus.MD_Stall  = ((state_q == S_IDLE) & md_bus.E_MulDiv & ~md_bus.E_Flush) |
                            (state_q == S_CALC);
  assign md_bus.MD_Done   = (state_q == S_DONE);
  assign md_bus.MD_Result = result_q;
  assign md_bus.MD_Rd     = rd_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  ex_muldiv_unit_if bus_if ();

  ex_muldiv_unit dut (
    .clk    (clk),
    .rst    (rst),
    .md_bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        special;
  } vec_t;

  vec_t vecs[19];

`ifdef MULDIV_EARLY_OUT_EN
  localparam int SPECIAL_LAT   = 2;
  localparam int SPECIAL_STALL = 1;
`else
  localparam int SPECIAL_LAT   = 34;
  localparam int SPECIAL_STALL = 33;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op and hold it in EX until the done pulse (bounded wait).
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat, output int stalls, output logic to);
    @(negedge clk);
    bus_if.E_Funct3 = f3;
    bus_if.E_SrcA   = a;
    bus_if.E_SrcB   = b;
    bus_if.E_Rd     = rd;
    bus_if.E_MulDiv = 1'b1;
    #1;
    lat    = 1;
    stalls = 0;
    to     = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (bus_if.MD_Stall === 1'b1) stalls++;
      if (bus_if.MD_Done === 1'b1) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
      #1;
      lat++;
    end
    bus_if.E_MulDiv = 1'b0;
  endtask

  initial begin
    int   lat;
    int   stalls;
    logic to;
    int   done_cnt;

    errors = 0;
    checks = 0;

    vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
    vecs[2]  = '{3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{3'b101, 32'd100,       32'd7,         32'd14,        1'b0};
    vecs[7]  = '{3'b111, 32'd100,       32'd7,         32'd2,         1'b0};
    vecs[8]  = '{3'b101, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{3'b111, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1'b1};
    vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[12] = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
    vecs[13] = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 1'b1};
    vecs[14] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vecs[15] = '{3'b100, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0};
    vecs[16] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[17] = '{3'b000, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 1'b0};
    vecs[18] = '{3'b110, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0};

    bus_if.E_MulDiv = 1'b0;
    bus_if.E_Funct3 = 3'd0;
    bus_if.E_SrcA   = 32'd0;
    bus_if.E_SrcB   = 32'd0;
    bus_if.E_Rd     = 5'd0;
    bus_if.E_Flush  = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_stall",  {31'd0, bus_if.MD_Stall}, 32'd0);
    check("reset_done",   {31'd0, bus_if.MD_Done},  32'd0);
    check("reset_result", bus_if.MD_Result,         32'd0);
    check("reset_rd",     {27'd0, bus_if.MD_Rd},    32'd0);
    rst = 1'b0;

    // Table-driven operations
    for (int i = 0; i < 19; i++) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 5), lat, stalls, to);
      check($sformatf("v%0d_timeout", i), {31'd0, to}, 32'd0);
      check($sformatf("v%0d_result", i), bus_if.MD_Result, vecs[i].exp);
      check($sformatf("v%0d_rd", i), {27'd0, bus_if.MD_Rd}, 32'(i + 5));
      check($sformatf("v%0d_latency", i), 32'(lat), vecs[i].special ? 32'(SPECIAL_LAT) : 32'd34);
      check($sformatf("v%0d_stall_cycles", i), 32'(stalls),
            vecs[i].special ? 32'(SPECIAL_STALL) : 32'd33);
      check($sformatf("v%0d_done_stall", i), {31'd0, bus_if.MD_Stall}, 32'd0);
    end

    // Flush on the 10th CALC cycle: back to IDLE, no done, result held
    @(negedge clk);
    bus_if.E_Funct3 = 3'b101;
    bus_if.E_SrcA   = 32'd100;
    bus_if.E_SrcB   = 32'd7;
    bus_if.E_Rd     = 5'd3;
    bus_if.E_MulDiv = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("flush_pre_stall", {31'd0, bus_if.MD_Stall}, 32'd1);
    bus_if.E_Flush  = 1'b1;
    bus_if.E_MulDiv = 1'b0;
    @(negedge clk);
    #1;
    bus_if.E_Flush = 1'b0;
    check("flush_stall",  {31'd0, bus_if.MD_Stall}, 32'd0);
    check("flush_done",   {31'd0, bus_if.MD_Done},  32'd0);
    check("flush_result", bus_if.MD_Result,         32'hFFFF_FFFE);
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus_if.MD_Done === 1'b1) done_cnt++;
    end
    check("flush_no_done", 32'(done_cnt), 32'd0);
    check("flush_result_held", bus_if.MD_Result, 32'hFFFF_FFFE);

    // Reset pulse mid-CALC, then a fresh DIVU 9/3
    @(negedge clk);
    bus_if.E_Funct3 = 3'b000;
    bus_if.E_SrcA   = 32'd5;
    bus_if.E_SrcB   = 32'd6;
    bus_if.E_Rd     = 5'd7;
    bus_if.E_MulDiv = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    bus_if.E_MulDiv = 1'b0;
    @(negedge clk);
    #1;
    check("rst_mid_stall",  {31'd0, bus_if.MD_Stall}, 32'd0);
    check("rst_mid_done",   {31'd0, bus_if.MD_Done},  32'd0);
    check("rst_mid_result", bus_if.MD_Result,         32'd0);
    check("rst_mid_rd",     {27'd0, bus_if.MD_Rd},    32'd0);
    rst = 1'b0;
    run_op(3'b101, 32'd9, 32'd3, 5'd9, lat, stalls, to);
    check("post_rst_timeout", {31'd0, to}, 32'd0);
    check("post_rst_result", bus_if.MD_Result, 32'd3);
    check("post_rst_rd", {27'd0, bus_if.MD_Rd}, 32'd9);
    check("post_rst_latency", 32'(lat), 32'd34);
    check("post_rst_stall_cycles", 32'(stalls), 32'd33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
